// File: rtl/addrgen_gen2.sv
// Convolution window address generator: emits two kernel-tap addresses per beat
// over a valid/ready handshake. Define ADDRGEN_PAD_EN to honour PAD and add pad_a/pad_b.
module addrgen_gen2 #(
    parameter int IN_W     = 8,
    parameter int IN_H     = 8,
    parameter int K        = 3,
    parameter int STRIDE   = 1,
    parameter int CH       = 2,
    parameter int NUM_PASS = 1,
    parameter int PAD      = 0,
    parameter int ADDR_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              addr_ready,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              b_valid,
    output logic              last,
    output logic              done,
    output logic              busy,
`ifdef ADDRGEN_PAD_EN
    output logic              pad_a,
    output logic              pad_b,
`endif
    output logic [1:0]        dbg_state
);

    // Handshake: a beat transfers on any rising edge where addr_valid && addr_ready;
    // while addr_valid && !addr_ready every output holds its value.

`ifdef ADDRGEN_PAD_EN
    localparam int P = PAD;
`else
    localparam int P = PAD * 0;
`endif

    localparam int OUT_W = (IN_W + 2*P - K) / STRIDE + 1;
    localparam int OUT_H = (IN_H + 2*P - K) / STRIDE + 1;
    localparam int KK    = K * K;
    localparam int NB    = (KK + 1) / 2;

    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PW = cw(NB);
    localparam int CW = cw(CH);
    localparam int JW = cw(OUT_W);
    localparam int IW = cw(OUT_H);
    localparam int SW = cw(NUM_PASS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

`ifdef ADDRGEN_PAD_EN
    function automatic logic tap_pad(input int t, input int i, input int j);
        int row, col;
        row = i*STRIDE + t/K - P;
        col = j*STRIDE + t%K - P;
        return (row < 0) || (row >= IN_H) || (col < 0) || (col >= IN_W);
    endfunction
`endif

    // Signed integer arithmetic, truncated to the address width on the way out.
    function automatic logic [ADDR_W-1:0] tap_addr(input int t, input int c, input int i, input int j);
        int row, col, v;
        row = i*STRIDE + t/K - P;
        col = j*STRIDE + t%K - P;
        v   = c*IN_W*IN_H + row*IN_W + col;
`ifdef ADDRGEN_PAD_EN
        if (tap_pad(t, i, j)) v = 0;
`endif
        return ADDR_W'(v);
    endfunction

    state_t            r_state, w_next_state;
    logic [PW-1:0]     r_p, w_n_p;
    logic [CW-1:0]     r_c, w_n_c;
    logic [JW-1:0]     r_j, w_n_j;
    logic [IW-1:0]     r_i, w_n_i;
    logic [SW-1:0]     r_pass, w_n_pass;
    logic              r_valid, r_bv, r_last;
    logic [ADDR_W-1:0] r_a, r_b;
    logic              w_accept, w_load, w_clear, w_bv, w_last;
    logic [ADDR_W-1:0] w_tap_a, w_tap_b;

    assign w_accept = r_valid && addr_ready;
    assign w_load   = ((r_state == S_IDLE) && start) || ((r_state == S_RUN) && w_accept && !r_last);
    assign w_clear  = (r_state == S_RUN) && w_accept && r_last;

    // Index of the beat that will be presented after this cycle's load.
    always_comb begin
        w_n_p    = '0;
        w_n_c    = r_c;
        w_n_j    = r_j;
        w_n_i    = r_i;
        w_n_pass = r_pass;
        if (r_state == S_IDLE) begin
            w_n_c    = '0;
            w_n_j    = '0;
            w_n_i    = '0;
            w_n_pass = '0;
        end else if (r_p != PW'(NB-1)) begin
            w_n_p = r_p + 1'b1;
        end else if (r_c != CW'(CH-1)) begin
            w_n_c = r_c + 1'b1;
        end else begin
            w_n_c = '0;
            if (r_j != JW'(OUT_W-1)) begin
                w_n_j = r_j + 1'b1;
            end else begin
                w_n_j = '0;
                if (r_i != IW'(OUT_H-1)) begin
                    w_n_i = r_i + 1'b1;
                end else begin
                    w_n_i    = '0;
                    w_n_pass = r_pass + 1'b1;
                end
            end
        end
    end

    assign w_tap_a = tap_addr(2*int'(w_n_p), int'(w_n_c), int'(w_n_i), int'(w_n_j));
    assign w_tap_b = tap_addr(2*int'(w_n_p) + 1, int'(w_n_c), int'(w_n_i), int'(w_n_j));
    assign w_bv    = (2*int'(w_n_p) + 1) < KK;
    assign w_last  = (w_n_p == PW'(NB-1)) && (w_n_c == CW'(CH-1)) && (w_n_j == JW'(OUT_W-1)) &&
                     (w_n_i == IW'(OUT_H-1)) && (w_n_pass == SW'(NUM_PASS-1));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (w_accept && r_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

`ifdef ADDRGEN_PAD_EN
    logic r_pad_a, r_pad_b;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_p <= '0; r_c <= '0; r_j <= '0; r_i <= '0; r_pass <= '0;
            r_valid <= 1'b0; r_a <= '0; r_b <= '0; r_bv <= 1'b0; r_last <= 1'b0;
`ifdef ADDRGEN_PAD_EN
            r_pad_a <= 1'b0; r_pad_b <= 1'b0;
`endif
        end else if (w_load) begin
            r_p <= w_n_p; r_c <= w_n_c; r_j <= w_n_j; r_i <= w_n_i; r_pass <= w_n_pass;
            r_valid <= 1'b1;
            r_a     <= w_tap_a;
            r_b     <= w_bv ? w_tap_b : '0;
            r_bv    <= w_bv;
            r_last  <= w_last;
`ifdef ADDRGEN_PAD_EN
            r_pad_a <= tap_pad(2*int'(w_n_p), int'(w_n_i), int'(w_n_j));
            r_pad_b <= w_bv && tap_pad(2*int'(w_n_p) + 1, int'(w_n_i), int'(w_n_j));
`endif
        end else if (w_clear) begin
            r_p <= '0; r_c <= '0; r_j <= '0; r_i <= '0; r_pass <= '0;
            r_valid <= 1'b0; r_a <= '0; r_b <= '0; r_bv <= 1'b0; r_last <= 1'b0;
`ifdef ADDRGEN_PAD_EN
            r_pad_a <= 1'b0; r_pad_b <= 1'b0;
`endif
        end
    end

    assign addr_valid = r_valid;
    assign addr_a     = r_a;
    assign addr_b     = r_b;
    assign b_valid    = r_bv;
    assign last       = r_last;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;
`ifdef ADDRGEN_PAD_EN
    assign pad_a      = r_pad_a;
    assign pad_b      = r_pad_b;
`endif

endmodule

// File: tb/tb_addrgen_gen2.sv
// Bench for addrgen_gen2: several parameterisations driven with directed and random
// backpressure, each checked against a loop-nest reference of the window sweep.
module tb_addrgen_gen2;

`ifdef ADDRGEN_PAD_EN
    localparam int ND = 4;
`else
    localparam int ND = 3;
`endif
    localparam int LIMIT = 3000;

    typedef struct packed {
        logic        last;
        logic        pb;
        logic        pa;
        logic        bv;
        logic [11:0] b;
        logic [11:0] a;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        ready;
    logic        start_v [ND];
    logic        v_valid [ND];
    logic [11:0] v_a     [ND];
    logic [11:0] v_b     [ND];
    logic        v_bv    [ND];
    logic        v_last  [ND];
    logic        v_done  [ND];
    logic        v_busy  [ND];
    logic [1:0]  v_state [ND];
`ifdef ADDRGEN_PAD_EN
    logic        v_pa    [ND];
    logic        v_pb    [ND];
`endif

    beat_t exp_q[$];
    beat_t obs_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;
    int    nbeats;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- DUTs ----------------
    addrgen_gen2 #(.IN_W(4), .IN_H(4), .K(3), .STRIDE(1), .CH(1), .NUM_PASS(1), .PAD(0), .ADDR_W(12)) u_d0 (
        .clk(clk), .reset(rst_n), .start(start_v[0]), .addr_ready(ready),
        .addr_valid(v_valid[0]), .addr_a(v_a[0]), .addr_b(v_b[0]), .b_valid(v_bv[0]),
        .last(v_last[0]), .done(v_done[0]), .busy(v_busy[0]),
`ifdef ADDRGEN_PAD_EN
        .pad_a(v_pa[0]), .pad_b(v_pb[0]),
`endif
        .dbg_state(v_state[0]));

    addrgen_gen2 #(.IN_W(4), .IN_H(4), .K(3), .STRIDE(1), .CH(2), .NUM_PASS(1), .PAD(0), .ADDR_W(12)) u_d1 (
        .clk(clk), .reset(rst_n), .start(start_v[1]), .addr_ready(ready),
        .addr_valid(v_valid[1]), .addr_a(v_a[1]), .addr_b(v_b[1]), .b_valid(v_bv[1]),
        .last(v_last[1]), .done(v_done[1]), .busy(v_busy[1]),
`ifdef ADDRGEN_PAD_EN
        .pad_a(v_pa[1]), .pad_b(v_pb[1]),
`endif
        .dbg_state(v_state[1]));

    addrgen_gen2 #(.IN_W(6), .IN_H(5), .K(2), .STRIDE(2), .CH(2), .NUM_PASS(2), .PAD(0), .ADDR_W(12)) u_d2 (
        .clk(clk), .reset(rst_n), .start(start_v[2]), .addr_ready(ready),
        .addr_valid(v_valid[2]), .addr_a(v_a[2]), .addr_b(v_b[2]), .b_valid(v_bv[2]),
        .last(v_last[2]), .done(v_done[2]), .busy(v_busy[2]),
`ifdef ADDRGEN_PAD_EN
        .pad_a(v_pa[2]), .pad_b(v_pb[2]),
`endif
        .dbg_state(v_state[2]));

`ifdef ADDRGEN_PAD_EN
    addrgen_gen2 #(.IN_W(4), .IN_H(4), .K(3), .STRIDE(1), .CH(1), .NUM_PASS(1), .PAD(1), .ADDR_W(12)) u_d3 (
        .clk(clk), .reset(rst_n), .start(start_v[3]), .addr_ready(ready),
        .addr_valid(v_valid[3]), .addr_a(v_a[3]), .addr_b(v_b[3]), .b_valid(v_bv[3]),
        .last(v_last[3]), .done(v_done[3]), .busy(v_busy[3]),
        .pad_a(v_pa[3]), .pad_b(v_pb[3]),
        .dbg_state(v_state[3]));
`endif

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t get_cur(input int sel);
        beat_t cur;
        cur      = '0;
        cur.a    = v_a[sel];
        cur.b    = v_b[sel];
        cur.bv   = v_bv[sel];
        cur.last = v_last[sel];
`ifdef ADDRGEN_PAD_EN
        cur.pa   = v_pa[sel];
        cur.pb   = v_pb[sel];
`endif
        return cur;
    endfunction

    // Reference: the window sweep written as the plain loop nest.
    task automatic build_exp(input int inw, input int inh, input int k, input int s,
                             input int ch, input int np, input int pd);
        int    ow, oh, nb, t, row, col, ad;
        logic  outside;
        beat_t e;
        exp_q.delete();
        ow = (inw + 2*pd - k) / s + 1;
        oh = (inh + 2*pd - k) / s + 1;
        nb = (k*k + 1) / 2;
        for (int ps = 0; ps < np; ps++)
            for (int i = 0; i < oh; i++)
                for (int j = 0; j < ow; j++)
                    for (int c = 0; c < ch; c++)
                        for (int p = 0; p < nb; p++) begin
                            e = '0;
                            for (int h = 0; h < 2; h++) begin
                                t = 2*p + h;
                                if (t < k*k) begin
                                    row     = i*s + t/k - pd;
                                    col     = j*s + t%k - pd;
                                    outside = (row < 0) || (row >= inh) || (col < 0) || (col >= inw);
                                    ad      = outside ? 0 : c*inw*inh + row*inw + col;
                                    if (h == 0) begin
                                        e.a  = ad[11:0];
                                        e.pa = outside;
                                    end else begin
                                        e.b  = ad[11:0];
                                        e.pb = outside;
                                        e.bv = 1'b1;
                                    end
                                end
                            end
                            e.last = (ps == np-1) && (i == oh-1) && (j == ow-1) && (c == ch-1) && (p == nb-1);
                            exp_q.push_back(e);
                        end
    endtask

    // ---------------- driver ----------------
    // mode 0: ready always high; 1: random ready; 2: ready low 3 cycles on beat 2.
    task automatic run_job(input int sel, input int mode, input int restart_at,
                           input int abort_at, output int nb_out);
        int    cyc, acc, stall;
        logic  prev_hold, restarted, aborted;
        beat_t prev, cur;
        cyc = 0; acc = 0; stall = 0;
        prev_hold = 1'b0; restarted = 1'b0; aborted = 1'b0;
        prev = '0;
        obs_q.delete();
        @(negedge clk);
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v[sel] = 1'b0;
        while (exp_q.size() > 0 && cyc < LIMIT) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = ($urandom_range(0, 3) != 0);
                default: begin
                    ready = !(acc == 1 && stall < 3);
                    if (!ready) stall++;
                end
            endcase
            cur = get_cur(sel);
            chk("valid_in_run", 32'(v_valid[sel]), 32'd1);
            chk("busy_in_run", 32'(v_busy[sel]), 32'd1);
            if (prev_hold) chk("hold_stable", 32'(cur), 32'(prev));
            if (v_valid[sel] && ready) begin
                chk($sformatf("beat%0d", acc + 1), 32'(cur), 32'(exp_q[0]));
                obs_q.push_back(cur);
                void'(exp_q.pop_front());
                acc++;
                if (acc == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    chk("abort_outputs", 32'(get_cur(sel)), 32'd0);
                    chk("abort_valid", 32'(v_valid[sel]), 32'd0);
                    chk("abort_busy", 32'(v_busy[sel]), 32'd0);
                    chk("abort_done", 32'(v_done[sel]), 32'd0);
                    repeat (2) @(negedge clk);
                    rst_n = 1'b1;
                    for (int w = 0; w < 3; w++) begin
                        @(negedge clk);
                        chk("post_abort_done", 32'(v_done[sel]), 32'd0);
                        chk("post_abort_valid", 32'(v_valid[sel]), 32'd0);
                    end
                    aborted = 1'b1;
                    exp_q.delete();
                    break;
                end
            end
            prev_hold = v_valid[sel] && !ready;
            prev      = cur;
            if (acc == restart_at && !restarted) begin
                start_v[sel] = 1'b1;
                restarted    = 1'b1;
            end else begin
                start_v[sel] = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start_v[sel] = 1'b0;
        chk("job_beats_left", 32'(exp_q.size()), 32'd0);
        if (!aborted) begin
            chk("done_pulse", 32'(v_done[sel]), 32'd1);
            chk("valid_in_done", 32'(v_valid[sel]), 32'd0);
            chk("busy_in_done", 32'(v_busy[sel]), 32'd0);
            @(negedge clk);
            chk("done_width", 32'(v_done[sel]), 32'd0);
            chk("valid_after_done", 32'(v_valid[sel]), 32'd0);
        end
        nb_out = acc;
    endtask

    task automatic check_obs(input string tag, input int idx, input int a, input int b, input int bv);
        chk({tag, "_a"}, 32'(obs_q[idx].a), 32'(a));
        chk({tag, "_b"}, 32'(obs_q[idx].b), 32'(b));
        chk({tag, "_bv"}, 32'(obs_q[idx].bv), 32'(bv));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        ready = 1'b0;
        for (int s = 0; s < ND; s++) start_v[s] = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < ND; s++) begin
            chk("rst_beat", 32'(get_cur(s)), 32'd0);
            chk("rst_valid", 32'(v_valid[s]), 32'd0);
            chk("rst_done", 32'(v_done[s]), 32'd0);
            chk("rst_busy", 32'(v_busy[s]), 32'd0);
            chk("rst_state", 32'(v_state[s]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // 4x4, K=3, single channel, ready always high
        build_exp(4, 4, 3, 1, 1, 1, 0);
        run_job(0, 0, -1, -1, nbeats);
        chk("t1_count", 32'(nbeats), 32'd20);
        check_obs("t1_b1", 0, 0, 1, 1);
        check_obs("t1_b2", 1, 2, 4, 1);
        check_obs("t1_b3", 2, 5, 6, 1);
        check_obs("t1_b4", 3, 8, 9, 1);
        check_obs("t1_b5", 4, 10, 0, 0);
        chk("t1_last19", 32'(obs_q[18].last), 32'd0);
        chk("t1_last20", 32'(obs_q[19].last), 32'd1);

        // three-cycle stall on beat 2
        build_exp(4, 4, 3, 1, 1, 1, 0);
        run_job(0, 2, -1, -1, nbeats);
        chk("t2_count", 32'(nbeats), 32'd20);
        check_obs("t2_b2", 1, 2, 4, 1);

        // second start while running is ignored
        build_exp(4, 4, 3, 1, 1, 1, 0);
        run_job(0, 0, 3, -1, nbeats);
        chk("t3_count", 32'(nbeats), 32'd20);

        // reset mid-job, then a clean restart
        build_exp(4, 4, 3, 1, 1, 1, 0);
        run_job(0, 0, -1, 7, nbeats);
        chk("t4_abort_count", 32'(nbeats), 32'd7);
        build_exp(4, 4, 3, 1, 1, 1, 0);
        run_job(0, 1, -1, -1, nbeats);
        chk("t4_count", 32'(nbeats), 32'd20);
        check_obs("t4_b1", 0, 0, 1, 1);

        // two channels, random backpressure
        build_exp(4, 4, 3, 1, 2, 1, 0);
        run_job(1, 1, -1, -1, nbeats);
        chk("t5_count", 32'(nbeats), 32'd40);
        check_obs("t5_b6", 5, 16, 17, 1);

        // non-square map, even kernel, stride 2, two passes
        build_exp(6, 5, 2, 2, 2, 2, 0);
        run_job(2, 1, -1, -1, nbeats);
        chk("t6_count", 32'(nbeats), 32'd48);

`ifdef ADDRGEN_PAD_EN
        build_exp(4, 4, 3, 1, 1, 1, 1);
        run_job(3, 1, -1, -1, nbeats);
        chk("t7_count", 32'(nbeats), 32'd80);
        chk("t7_b1_pa", 32'(obs_q[0].pa), 32'd1);
        chk("t7_b1_pb", 32'(obs_q[0].pb), 32'd1);
        check_obs("t7_b1", 0, 0, 0, 1);
        chk("t7_b3_a", 32'(obs_q[2].a), 32'd0);
        chk("t7_b3_pa", 32'(obs_q[2].pa), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
